rgmii_udp_tx_sequencer: RTL and testbench

Frame-level TX controller for the RGMII UDP path. It latches the host/FPGA MAC, IP and port configuration plus the payload length from the register block, then builds the Ethernet/IPv4/UDP header and computes the IPv4 header checksum. It emits the header bytes followed by the payload bytes as one byte-wide stream to the MAC TX stage. The MAC TX stage downstream adds the preamble, SFD and FCS.

---
 rtl/rgmii_udp_tx_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rgmii_udp_tx_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_udp_tx_sequencer.sv
// rtl/rgmii_udp_tx_sequencer.sv - Ethernet/IPv4/UDP header builder and byte sequencer for the RGMII TX path

package rgmii_udp_pkg;

  typedef struct packed {
    logic [15:0] payload_bytes;
    logic        reset;
  } rgmii_control_t;

  typedef struct packed {
    logic [47:0]    host_mac;
    logic [47:0]    fpga_mac;
    logic [31:0]    host_ip;
    logic [31:0]    fpga_ip;
    logic [15:0]    host_port;
    logic [15:0]    fpga_port;
    rgmii_control_t control;
  } rgmii_config_t;

  // Fields are declared in wire order: the first field sits in the MSBs and its
  // MSB byte is the first byte sent, so the frame is emitted MSB byte first.
  typedef struct packed {
    logic [47:0] mac_destination;
    logic [47:0] mac_source;
    logic [15:0] eth_type_length;
    logic [7:0]  version_ihl;
    logic [7:0]  tos;
    logic [15:0] total_length;
    logic [15:0] identification;
    logic [15:0] flags_fragment_offset;
    logic [7:0]  time_to_live;
    logic [7:0]  protocol;
    logic [15:0] header_checksum;
    logic [31:0] ip_source;
    logic [31:0] ip_destination;
    logic [15:0] port_source;
    logic [15:0] port_destination;
    logic [15:0] length;
    logic [15:0] udp_checksum;
  } ethernet_header_t;

endpackage

module rgmii_udp_tx_sequencer
  import rgmii_udp_pkg::*;
#(
  parameter int TTL         = 64,
  parameter int MAX_PAYLOAD = 1472,
  parameter int MIN_PAYLOAD = 18
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  rgmii_config_t cfg_i,
  input  logic [7:0]    s_axis_tdata_i,
  input  logic          s_axis_tvalid_i,
  output logic          s_axis_tready_o,
  output logic [7:0]    m_axis_tdata_o,
  output logic          m_axis_tvalid_o,
  input  logic          m_axis_tready_i,
  output logic          m_axis_tlast_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int          HDR_BYTES = 42;
  localparam int          HDR_BITS  = HDR_BYTES * 8;
  localparam logic [10:0] MAX_LEN   = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_LEN   = 11'(MIN_PAYLOAD);
  localparam logic [10:0] HDR_LAST  = 11'(HDR_BYTES - 1);
  localparam logic [7:0]  TTL_BYTE  = 8'(TTL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HEADER,
    S_PAYLOAD,
    S_PAD
  } state_t;

  state_t               state;
  ethernet_header_t     hdr;
  ethernet_header_t     hdr_full;
  logic [HDR_BITS-1:0]  shift;
  logic [10:0]          len;
  logic [10:0]          cnt;
  logic [15:0]          acc;
  logic [15:0]          ident;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 last_q;

  logic [10:0]          start_len;
  logic [15:0]          csum_word;
  logic [16:0]          csum_sum;
  logic [10:0]          pad_len;
  logic                 in_payload;
  logic                 payload_last;
  logic                 hs;

  // Clamp the requested payload length to the largest UDP payload a 1500-byte MTU allows.
  always_comb begin
    start_len = cfg_i.control.payload_bytes[10:0];
    if (cfg_i.control.payload_bytes > 16'(MAX_PAYLOAD)) begin
      start_len = MAX_LEN;
    end
  end

  // Select the IPv4 header word for this checksum step; the checksum word itself counts as zero.
  always_comb begin
    csum_word = 16'h0000;
    case (cnt[3:0])
      4'd0:    csum_word = {hdr.version_ihl, hdr.tos};
      4'd1:    csum_word = hdr.total_length;
      4'd2:    csum_word = hdr.identification;
      4'd3:    csum_word = hdr.flags_fragment_offset;
      4'd4:    csum_word = {hdr.time_to_live, hdr.protocol};
      4'd5:    csum_word = 16'h0000;
      4'd6:    csum_word = hdr.ip_source[31:16];
      4'd7:    csum_word = hdr.ip_source[15:0];
      4'd8:    csum_word = hdr.ip_destination[31:16];
      4'd9:    csum_word = hdr.ip_destination[15:0];
      default: csum_word = 16'h0000;
    endcase
    csum_sum = {1'b0, acc} + {1'b0, csum_word};
  end

  // Header image with the finished checksum inserted, used on the CSUM exit cycle.
  always_comb begin
    hdr_full                 = hdr;
    hdr_full.header_checksum = ~acc;
  end

  assign pad_len      = MIN_LEN - len;
  assign in_payload   = (state == S_PAYLOAD);
  assign payload_last = (cnt == len - 11'd1);

  // Payload bytes pass straight through; header and pad bytes come from registers.
  assign m_axis_tdata_o  = in_payload ? s_axis_tdata_i  : data_q;
  assign m_axis_tvalid_o = in_payload ? s_axis_tvalid_i : valid_q;
  assign m_axis_tlast_o  = in_payload ? (payload_last && (len >= MIN_LEN)) : last_q;
  assign s_axis_tready_o = in_payload & m_axis_tready_i;
  assign busy_o          = (state != S_IDLE);
  assign hs              = m_axis_tvalid_o & m_axis_tready_i;
  assign frame_done_o    = hs & m_axis_tlast_o;

  // Frame sequencer: latch config, checksum, then header, payload and pad bytes.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state   <= S_IDLE;
      hdr     <= '0;
      shift   <= '0;
      len     <= '0;
      cnt     <= '0;
      acc     <= '0;
      ident   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_axis_tvalid_i && !cfg_i.control.reset) begin
            hdr.mac_destination       <= cfg_i.host_mac;
            hdr.mac_source            <= cfg_i.fpga_mac;
            hdr.eth_type_length       <= 16'h0800;
            hdr.version_ihl           <= 8'h45;
            hdr.tos                   <= 8'h00;
            hdr.total_length          <= 16'd28 + 16'(start_len);
            hdr.identification        <= ident;
            hdr.flags_fragment_offset <= 16'h4000;
            hdr.time_to_live          <= TTL_BYTE;
            hdr.protocol              <= 8'h11;
            hdr.header_checksum       <= 16'h0000;
            hdr.ip_source             <= cfg_i.fpga_ip;
            hdr.ip_destination        <= cfg_i.host_ip;
            hdr.port_source           <= cfg_i.fpga_port;
            hdr.port_destination      <= cfg_i.host_port;
            hdr.length                <= 16'd8 + 16'(start_len);
            hdr.udp_checksum          <= 16'h0000;
            len                       <= start_len;
            cnt                       <= '0;
            acc                       <= '0;
            state                     <= S_CSUM;
          end
        end

        S_CSUM: begin
          if (cnt == 11'd10) begin
            hdr.header_checksum <= ~acc;
            shift               <= {hdr_full[HDR_BITS-9:0], 8'h00};
            data_q              <= hdr_full[HDR_BITS-1 -: 8];
            valid_q             <= 1'b1;
            last_q              <= 1'b0;
            cnt                 <= '0;
            state               <= S_HEADER;
          end else begin
            // End-around carry folded every step keeps the running sum in 16 bits.
            acc <= csum_sum[15:0] + {15'd0, csum_sum[16]};
            cnt <= cnt + 11'd1;
          end
        end

        S_HEADER: begin
          if (hs) begin
            if (cnt == HDR_LAST) begin
              cnt    <= '0;
              data_q <= 8'h00;
              if (len == 11'd0) begin
                valid_q <= 1'b1;
                last_q  <= (MIN_LEN == 11'd1);
                state   <= S_PAD;
              end else begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                state   <= S_PAYLOAD;
              end
            end else begin
              data_q <= shift[HDR_BITS-1 -: 8];
              shift  <= {shift[HDR_BITS-9:0], 8'h00};
              cnt    <= cnt + 11'd1;
            end
          end
        end

        S_PAYLOAD: begin
          if (hs) begin
            if (payload_last) begin
              cnt <= '0;
              if (len < MIN_LEN) begin
                data_q  <= 8'h00;
                valid_q <= 1'b1;
                last_q  <= (pad_len == 11'd1);
                state   <= S_PAD;
              end else begin
                ident <= ident + 16'd1;
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt + 11'd1;
            end
          end
        end

        S_PAD: begin
          if (hs) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              cnt     <= '0;
              ident   <= ident + 16'd1;
              state   <= S_IDLE;
            end else begin
              cnt    <= cnt + 11'd1;
              last_q <= ((cnt + 11'd2) == pad_len);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_udp_tx_sequencer.sv
// tb/tb_rgmii_udp_tx_sequencer.sv - directed self-checking bench for rgmii_udp_tx_sequencer

module tb_rgmii_udp_tx_sequencer;
  import rgmii_udp_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  rgmii_config_t cfg;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          frame_done;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    got_q[$];
  int            got_last_idx;
  int            last_count;
  int            done_count;
  int            first_valid_cyc;
  int            done_cyc;
  int            stab_err;
  int            tready_seen;
  logic [15:0]   exp_id;

  always #5 clk = ~clk;

  rgmii_udp_tx_sequencer dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_i           (cfg),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .m_axis_tlast_o  (m_tlast),
    .busy_o          (busy),
    .frame_done_o    (frame_done)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 90) & 255);
  endfunction

  // Reference frame: header from the field list, checksum summed wide and folded at the end.
  task automatic build_expected(input rgmii_config_t c, input int l, input logic [15:0] idv);
    logic [7:0]  h [0:41];
    logic [31:0] sum;
    logic [15:0] tl;
    logic [15:0] ul;
    logic [15:0] ck;
    tl = 16'(28 + l);
    ul = 16'(8 + l);
    for (int i = 0; i < 6; i++) begin
      h[i]   = 8'(c.host_mac >> (40 - 8 * i));
      h[6+i] = 8'(c.fpga_mac >> (40 - 8 * i));
    end
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[15] = 8'h00;
    h[16] = tl[15:8]; h[17] = tl[7:0]; h[18] = idv[15:8]; h[19] = idv[7:0];
    h[20] = 8'h40; h[21] = 8'h00; h[22] = 8'd64; h[23] = 8'h11;
    h[24] = 8'h00; h[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      h[26+i] = 8'(c.fpga_ip >> (24 - 8 * i));
      h[30+i] = 8'(c.host_ip >> (24 - 8 * i));
    end
    h[34] = c.fpga_port[15:8]; h[35] = c.fpga_port[7:0];
    h[36] = c.host_port[15:8]; h[37] = c.host_port[7:0];
    h[38] = ul[15:8]; h[39] = ul[7:0]; h[40] = 8'h00; h[41] = 8'h00;
    sum = 32'd0;
    for (int w = 0; w < 10; w++) sum = sum + {16'h0000, h[14+2*w], h[15+2*w]};
    sum = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
    sum = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
    ck = ~sum[15:0];
    h[24] = ck[15:8]; h[25] = ck[7:0];
    exp_q.delete();
    for (int i = 0; i < 42; i++) exp_q.push_back(h[i]);
    for (int i = 0; i < l; i++) exp_q.push_back(pat(i));
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  // Drives one frame and records what the DUT emits; mode 1 randomises m_tready.
  task automatic run_frame(input int mode, input int abort_at, input int soft_at);
    int   c;
    int   src;
    int   l;
    bit   done;
    bit   prev_stall;
    logic [7:0] prev_d;
    c = 0; src = 0; done = 0; prev_stall = 0; prev_d = 8'h00;
    l = (cfg.control.payload_bytes > 16'd1472) ? 1472 : int'(cfg.control.payload_bytes);
    got_q.delete();
    last_count = 0; got_last_idx = -1; done_count = 0;
    first_valid_cyc = -1; done_cyc = -1; stab_err = 0; tready_seen = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      if (c == soft_at) begin
        cfg.control.reset         = 1'b1;
        cfg.control.payload_bytes = 16'd3;
        cfg.host_mac              = 48'hDEAD_BEEF_0000;
        cfg.fpga_ip               = 32'h0A00_0001;
      end
      s_tvalid = (l == 0) ? 1'b1 : (src < l);
      s_tdata  = (src < l) ? pat(src) : 8'hEE;
      m_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d)) stab_err++;
      if (m_tvalid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = c;
      if (s_tready === 1'b1) tready_seen++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        got_q.push_back(m_tdata);
        if (m_tlast === 1'b1) begin
          last_count++;
          got_last_idx = got_q.size() - 1;
        end
      end
      if (frame_done === 1'b1) begin
        done_count++;
        done_cyc = c;
        done = 1;
      end
      if (s_tvalid === 1'b1 && s_tready === 1'b1) src++;
      prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      prev_d = m_tdata;
      if (abort_at >= 0 && got_q.size() == abort_at) break;
      c++;
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic set_default_cfg(input logic [15:0] pb);
    cfg.host_mac              = 48'h0011_2233_4455;
    cfg.fpga_mac              = 48'h0200_0A0B_0C0D;
    cfg.host_ip               = 32'hC0A8_0002;
    cfg.fpga_ip               = 32'hC0A8_0001;
    cfg.host_port             = 16'd5000;
    cfg.fpga_port             = 16'd1234;
    cfg.control.payload_bytes = pb;
    cfg.control.reset         = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hA5; m_tready = 1'b1;
    set_default_cfg(16'd18);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b expected 0", s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", frame_done); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h expected 00", m_tdata); end
    s_tvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_id = 16'h0000;
  endtask

  task automatic test_checksum_pad();
    int nbad;
    set_default_cfg(16'd18);
    build_expected(cfg, 18, exp_id);
    run_frame(0, -1, -1);
    exp_id++;
    checks++; if (got_q.size() != 60) begin errors++; $display("FAIL cs_count: got %0d bytes expected 60", got_q.size()); end
    checks++; if ({got_q[16], got_q[17]} !== 16'h002E) begin errors++; $display("FAIL cs_total_length: got %h%h expected 002e", got_q[16], got_q[17]); end
    checks++; if ({got_q[38], got_q[39]} !== 16'h001A) begin errors++; $display("FAIL cs_udp_length: got %h%h expected 001a", got_q[38], got_q[39]); end
    checks++; if ({got_q[24], got_q[25]} !== 16'hB96B) begin errors++; $display("FAIL cs_checksum: got %h%h expected b96b", got_q[24], got_q[25]); end
    checks++; if ({got_q[18], got_q[19]} !== 16'h0000) begin errors++; $display("FAIL cs_ident: got %h%h expected 0000", got_q[18], got_q[19]); end
    checks++; if (got_last_idx != 59 || last_count != 1) begin errors++; $display("FAIL cs_tlast: got idx %0d count %0d expected idx 59 count 1", got_last_idx, last_count); end
    checks++; if (first_valid_cyc != 12) begin errors++; $display("FAIL cs_latency: got cycle %0d expected 12", first_valid_cyc); end
    checks++; if (done_cyc != 71 || done_count != 1) begin errors++; $display("FAIL cs_done: got cycle %0d count %0d expected 71 1", done_cyc, done_count); end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL cs_bytes: got %0d differing bytes expected 0", nbad); end
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cs_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_zero_payload();
    int nbad;
    set_default_cfg(16'd0);
    build_expected(cfg, 0, exp_id);
    run_frame(0, -1, -1);
    exp_id++;
    idle_inputs();
    checks++; if (got_q.size() != 60) begin errors++; $display("FAIL zp_count: got %0d bytes expected 60", got_q.size()); end
    checks++; if (tready_seen != 0) begin errors++; $display("FAIL zp_tready: got %0d ready cycles expected 0", tready_seen); end
    checks++; if (got_last_idx != 59 || last_count != 1) begin errors++; $display("FAIL zp_tlast: got idx %0d count %0d expected idx 59 count 1", got_last_idx, last_count); end
    checks++; if (done_cyc != 71) begin errors++; $display("FAIL zp_done: got cycle %0d expected 71", done_cyc); end
    nbad = 0;
    for (int i = 42; i < 60; i++) if (i >= got_q.size() || got_q[i] !== 8'h00) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL zp_pad: got %0d nonzero pad bytes expected 0", nbad); end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL zp_bytes: got %0d differing bytes expected 0", nbad); end
  endtask

  task automatic test_backpressure();
    int nbad;
    set_default_cfg(16'd100);
    cfg.host_ip = 32'h0A01_0203;
    build_expected(cfg, 100, exp_id);
    run_frame(1, -1, -1);
    exp_id++;
    idle_inputs();
    checks++; if (got_q.size() != 142) begin errors++; $display("FAIL bp_count: got %0d bytes expected 142", got_q.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stab_err); end
    checks++; if (got_last_idx != 141 || done_count != 1) begin errors++; $display("FAIL bp_tlast: got idx %0d done %0d expected 141 1", got_last_idx, done_count); end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL bp_bytes: got %0d differing bytes expected 0", nbad); end
  endtask

  task automatic test_clamp();
    int nbad;
    set_default_cfg(16'd2000);
    build_expected(cfg, 1472, exp_id);
    run_frame(0, -1, -1);
    exp_id++;
    idle_inputs();
    checks++; if (got_q.size() != 1514) begin errors++; $display("FAIL cl_count: got %0d bytes expected 1514", got_q.size()); end
    checks++; if ({got_q[16], got_q[17]} !== 16'h05DC) begin errors++; $display("FAIL cl_total_length: got %h%h expected 05dc", got_q[16], got_q[17]); end
    checks++; if ({got_q[38], got_q[39]} !== 16'h05C8) begin errors++; $display("FAIL cl_udp_length: got %h%h expected 05c8", got_q[38], got_q[39]); end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL cl_bytes: got %0d differing bytes expected 0", nbad); end
  endtask

  task automatic test_soft_reset();
    int nbad;
    int nbusy;
    set_default_cfg(16'd18);
    cfg.control.reset = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = 8'h11; m_tready = 1'b1;
      #1;
      if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) nbusy++;
    end
    checks++; if (nbusy != 0) begin errors++; $display("FAIL sr_idle_hold: got %0d active cycles expected 0", nbusy); end
    idle_inputs();
    cfg.control.reset = 1'b0;
    set_default_cfg(16'd20);
    build_expected(cfg, 20, exp_id);
    run_frame(0, -1, 20);
    exp_id++;
    checks++; if (done_count != 1 || got_q.size() != 62) begin errors++; $display("FAIL sr_mid_frame: got done %0d bytes %0d expected 1 62", done_count, got_q.size()); end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL sr_bytes: got %0d differing bytes expected 0", nbad); end
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      #1;
      if (busy !== 1'b0) nbusy++;
    end
    checks++; if (nbusy != 0) begin errors++; $display("FAIL sr_after_frame: got %0d busy cycles expected 0", nbusy); end
    idle_inputs();
    set_default_cfg(16'd18);
  endtask

  task automatic test_back_to_back();
    int nbad;
    int lens [3];
    lens[0] = 18; lens[1] = 30; lens[2] = 5;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    exp_id = 16'h0000;
    for (int f = 0; f < 3; f++) begin
      set_default_cfg(16'(lens[f]));
      cfg.fpga_ip = 32'hC0A8_0001 + 32'(f * 3);
      build_expected(cfg, lens[f], exp_id);
      run_frame(0, -1, -1);
      exp_id++;
      checks++; if ({got_q[18], got_q[19]} !== 16'(f)) begin errors++; $display("FAIL b2b_ident%0d: got %h%h expected %04h", f, got_q[18], got_q[19], 16'(f)); end
      checks++; if (first_valid_cyc != 12) begin errors++; $display("FAIL b2b_start%0d: got cycle %0d expected 12", f, first_valid_cyc); end
      nbad = 0;
      foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0 || got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_bytes%0d: got %0d differing of %0d bytes expected 0 of %0d", f, nbad, got_q.size(), exp_q.size()); end
    end
    idle_inputs();
  endtask

  task automatic test_id_wrap();
    set_default_cfg(16'd18);
    @(negedge clk);
    force dut.ident = 16'hFFFF;
    @(negedge clk);
    release dut.ident;
    exp_id = 16'hFFFF;
    build_expected(cfg, 18, exp_id);
    run_frame(0, -1, -1);
    exp_id++;
    checks++; if ({got_q[18], got_q[19]} !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h%h expected ffff", got_q[18], got_q[19]); end
    run_frame(0, -1, -1);
    exp_id++;
    checks++; if ({got_q[18], got_q[19]} !== 16'h0000) begin errors++; $display("FAIL wrap_0000: got %h%h expected 0000", got_q[18], got_q[19]); end
    idle_inputs();
  endtask

  task automatic test_hard_reset();
    int nbad;
    set_default_cfg(16'd100);
    run_frame(0, 50, -1);
    checks++; if (got_q.size() != 50) begin errors++; $display("FAIL hr_progress: got %0d bytes expected 50", got_q.size()); end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({m_tvalid, m_tlast, s_tready, busy, frame_done} !== 5'b00000 || m_tdata !== 8'h00) begin
      errors++; $display("FAIL hr_outputs: got v%b l%b r%b b%b d%b data %h expected all 0", m_tvalid, m_tlast, s_tready, busy, frame_done, m_tdata);
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_id = 16'h0000;
    set_default_cfg(16'd18);
    build_expected(cfg, 18, exp_id);
    run_frame(0, -1, -1);
    exp_id++;
    idle_inputs();
    checks++; if ({got_q[18], got_q[19]} !== 16'h0000) begin errors++; $display("FAIL hr_ident: got %h%h expected 0000", got_q[18], got_q[19]); end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0 || got_q.size() != 60) begin errors++; $display("FAIL hr_bytes: got %0d differing, %0d bytes expected 0, 60", nbad, got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_checksum_pad();
    test_zero_payload();
    test_backpressure();
    test_clamp();
    test_soft_reset();
    test_back_to_back();
    test_id_wrap();
    test_hard_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
